// File: rtl/ex_pkg.sv
// ex_pkg: shared types for the RV32I execute stage.
// Holds ALU/branch/MD/forwarding encodings and the EX/MEM bundle.
package ex_pkg;

   localparam int DIV_ITER = 32;

   typedef enum logic [3:0] {
      ALU_ADD   = 4'd0,
      ALU_SUB   = 4'd1,
      ALU_SLL   = 4'd2,
      ALU_SLT   = 4'd3,
      ALU_SLTU  = 4'd4,
      ALU_XOR   = 4'd5,
      ALU_SRL   = 4'd6,
      ALU_SRA   = 4'd7,
      ALU_OR    = 4'd8,
      ALU_AND   = 4'd9,
      ALU_PASSB = 4'd10,
      ALU_JALR  = 4'd11
   } alu_op_e;

   typedef enum logic [2:0] {
      BR_NONE = 3'd0,
      BR_EQ   = 3'd1,
      BR_NE   = 3'd2,
      BR_LT   = 3'd3,
      BR_GE   = 3'd4,
      BR_LTU  = 3'd5,
      BR_GEU  = 3'd6,
      BR_JUMP = 3'd7
   } br_op_e;

   typedef enum logic [2:0] {
      MD_MUL    = 3'd0,
      MD_MULH   = 3'd1,
      MD_MULHSU = 3'd2,
      MD_MULHU  = 3'd3,
      MD_DIV    = 3'd4,
      MD_DIVU   = 3'd5,
      MD_REM    = 3'd6,
      MD_REMU   = 3'd7
   } md_op_e;

   typedef enum logic [1:0] {
      FWD_RF  = 2'd0,
      FWD_MEM = 2'd1,
      FWD_WB  = 2'd2,
      FWD_RF3 = 2'd3
   } fwd_sel_e;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_CALC = 2'd1,
      MD_DONE = 2'd2
   } md_state_e;

   typedef struct packed {
      logic [31:0] alu_data;
      logic [31:0] rs2_data;
      logic [4:0]  rd_addr;
      logic [31:0] pc_four;
      logic        rd_wren;
      logic [8:0]  mem_en;
      logic [1:0]  wb_en;
      logic        ld_en;
      logic        pc_br;
   } ex_mem_t;

endpackage

// File: rtl/ex_cycle_if.sv
// ex_cycle_if: EX/MEM register outputs feeding mem_cycle.
// master = execute stage, slave = memory stage.
interface ex_cycle_if;

   logic [31:0] MEM_alu_data;
   logic [31:0] MEM_rs2_data;
   logic [4:0]  MEM_rd_addr;
   logic [31:0] MEM_pc_four;
   logic        MEM_rd_wren;
   logic [8:0]  MEM_mem_en;
   logic [1:0]  MEM_wb_en;
   logic        MEM_ld_en;
   logic        MEM_pc_br;

   modport master (
      output MEM_alu_data, MEM_rs2_data, MEM_rd_addr,
      output MEM_pc_four, MEM_rd_wren, MEM_mem_en,
      output MEM_wb_en, MEM_ld_en, MEM_pc_br
   );

   modport slave (
      input MEM_alu_data, MEM_rs2_data, MEM_rd_addr,
      input MEM_pc_four, MEM_rd_wren, MEM_mem_en,
      input MEM_wb_en, MEM_ld_en, MEM_pc_br
   );

endinterface

// File: rtl/md_unit.sv
// md_unit: RV32M single-cycle multiplier and 32-step restoring divider.
// Only instantiated by ex_cycle when RV32M_EN is defined.
module md_unit
   import ex_pkg::*;
(
   input  logic        clk_i,
   input  logic        clr_n,
   input  logic        stall_en,
   input  logic        md_en,
   input  logic [2:0]  md_op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   output logic        busy,
   output logic [31:0] result
);

   md_state_e          state_q, state_d;
   md_op_e             op;
   logic [4:0]         cnt_q, cnt_d;
   logic               start, busy_c, sgn;
   logic [31:0]        quo_q, rem_q, dvs_q, dvd_q;
   logic               is_rem_q, div0_q, negq_q, negr_q;
   logic [32:0]        shf, diff;
   logic [31:0]        mag_a, mag_b;
   logic [31:0]        quo_v, rem_v, mul_v;
   logic signed [32:0] mul_a, mul_b;
   logic signed [65:0] prod;
   logic               unused_prod;

   assign op    = md_op_e'(md_op);
   assign sgn   = ~md_op[0];
   assign start = md_en & md_op[2] & stall_en;
   assign mag_a = (sgn & src_a[31]) ? -src_a : src_a;
   assign mag_b = (sgn & src_b[31]) ? -src_b : src_b;

   // Divider state register; cleared by reset or pipeline flush
   always_ff @(posedge clk_i or negedge clr_n) begin
      if (!clr_n) begin
         state_q <= MD_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state and stall request
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy_c  = 1'b0;
      case (state_q)
         MD_IDLE: begin
            if (start) begin
               state_d = MD_CALC;
               cnt_d   = '0;
               busy_c  = 1'b1;
            end
         end
         MD_CALC: begin
            busy_c = 1'b1;
            cnt_d  = cnt_q + 5'd1;
            if (cnt_q == 5'(DIV_ITER - 1))
               state_d = MD_DONE;
         end
         MD_DONE: begin
            if (stall_en)
               state_d = MD_IDLE;
         end
         default: state_d = MD_IDLE;
      endcase
   end

   assign busy = busy_c & clr_n;

   assign shf  = {rem_q, quo_q[31]};
   assign diff = shf - {1'b0, dvs_q};

   // Operand latch on start, then one quotient bit per CALC cycle
   always_ff @(posedge clk_i or negedge clr_n) begin
      if (!clr_n) begin
         quo_q    <= '0;
         rem_q    <= '0;
         dvs_q    <= '0;
         dvd_q    <= '0;
         is_rem_q <= 1'b0;
         div0_q   <= 1'b0;
         negq_q   <= 1'b0;
         negr_q   <= 1'b0;
      end else if (state_q == MD_IDLE && start) begin
         quo_q    <= mag_a;
         rem_q    <= '0;
         dvs_q    <= mag_b;
         dvd_q    <= src_a;
         is_rem_q <= md_op[1];
         div0_q   <= (src_b == '0);
         negq_q   <= sgn & (src_a[31] ^ src_b[31]);
         negr_q   <= sgn & src_a[31];
      end else if (state_q == MD_CALC) begin
         quo_q <= {quo_q[30:0], ~diff[32]};
         rem_q <= diff[32] ? shf[31:0] : diff[31:0];
      end
   end

   // Sign fix-up; 0x80000000/-1 falls out of the magnitude path
   always_comb begin
      quo_v = negq_q ? -quo_q : quo_q;
      rem_v = negr_q ? -rem_q : rem_q;
      if (div0_q) begin
         quo_v = '1;
         rem_v = dvd_q;
      end
   end

   assign mul_a = {((op == MD_MULH) | (op == MD_MULHSU)) & src_a[31], src_a};
   assign mul_b = {(op == MD_MULH) & src_b[31], src_b};
   assign prod  = mul_a * mul_b;
   assign mul_v = (op == MD_MUL) ? prod[31:0] : prod[63:32];
   assign unused_prod = ^prod[65:64];

   assign result = md_op[2] ? (is_rem_q ? rem_v : quo_v) : mul_v;

endmodule

// File: rtl/ex_cycle.sv
// ex_cycle: RV32I execute stage and EX/MEM pipeline register.
// Define RV32M_EN to build in the multiply/divide unit.
module ex_cycle
   import ex_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        EX_stall_en,
   input  logic        EX_rst_n,
   input  logic [31:0] EX_pc,
   input  logic [31:0] EX_rs1_data,
   input  logic [31:0] EX_rs2_data,
   input  logic [31:0] EX_imm,
   input  logic [4:0]  EX_rd_addr,
   input  logic [1:0]  EX_fwd_a_sel,
   input  logic [1:0]  EX_fwd_b_sel,
   input  logic [31:0] WB_fwd_data,
   input  logic [3:0]  EX_alu_op,
   input  logic [1:0]  EX_op_sel,
   input  logic [2:0]  EX_br_op,
   input  logic        EX_md_en,
   input  logic [2:0]  EX_md_op,
   input  logic        EX_rd_wren,
   input  logic [8:0]  EX_mem_en,
   input  logic [1:0]  EX_wb_en,
   input  logic        EX_ld_en,
   output logic        EX_md_busy,
   ex_cycle_if.master  ex_mem
);

   logic        clr_n;
   logic [31:0] fwd_a, fwd_b, op_a, op_b;
   logic [31:0] alu_res, res;
   logic [4:0]  shamt;
   logic        br_take, md_busy;
   ex_mem_t     reg_q, reg_d;

   assign clr_n = rst_ni & EX_rst_n;

   // Operand forwarding from EX/MEM and WB
   always_comb begin
      fwd_a = EX_rs1_data;
      fwd_b = EX_rs2_data;
      case (fwd_sel_e'(EX_fwd_a_sel))
         FWD_MEM: fwd_a = reg_q.alu_data;
         FWD_WB:  fwd_a = WB_fwd_data;
         default: fwd_a = EX_rs1_data;
      endcase
      case (fwd_sel_e'(EX_fwd_b_sel))
         FWD_MEM: fwd_b = reg_q.alu_data;
         FWD_WB:  fwd_b = WB_fwd_data;
         default: fwd_b = EX_rs2_data;
      endcase
   end

   assign op_a  = EX_op_sel[0] ? EX_pc : fwd_a;
   assign op_b  = EX_op_sel[1] ? EX_imm : fwd_b;
   assign shamt = op_b[4:0];

   // ALU
   always_comb begin
      alu_res = '0;
      case (alu_op_e'(EX_alu_op))
         ALU_ADD:   alu_res = op_a + op_b;
         ALU_SUB:   alu_res = op_a - op_b;
         ALU_SLL:   alu_res = op_a << shamt;
         ALU_SLT:   alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
         ALU_SLTU:  alu_res = {31'd0, op_a < op_b};
         ALU_XOR:   alu_res = op_a ^ op_b;
         ALU_SRL:   alu_res = op_a >> shamt;
         ALU_SRA:   alu_res = $signed(op_a) >>> shamt;
         ALU_OR:    alu_res = op_a | op_b;
         ALU_AND:   alu_res = op_a & op_b;
         ALU_PASSB: alu_res = op_b;
         ALU_JALR:  alu_res = (op_a + op_b) & ~32'd1;
         default:   alu_res = '0;
      endcase
   end

   // Branch comparator on forwarded register operands
   always_comb begin
      br_take = 1'b0;
      case (br_op_e'(EX_br_op))
         BR_EQ:   br_take = (fwd_a == fwd_b);
         BR_NE:   br_take = (fwd_a != fwd_b);
         BR_LT:   br_take = ($signed(fwd_a) < $signed(fwd_b));
         BR_GE:   br_take = ($signed(fwd_a) >= $signed(fwd_b));
         BR_LTU:  br_take = (fwd_a < fwd_b);
         BR_GEU:  br_take = (fwd_a >= fwd_b);
         BR_JUMP: br_take = 1'b1;
         default: br_take = 1'b0;
      endcase
   end

`ifdef RV32M_EN
   logic [31:0] md_res;

   md_unit u_md (
      .clk_i    (clk_i),
      .clr_n    (clr_n),
      .stall_en (EX_stall_en),
      .md_en    (EX_md_en),
      .md_op    (EX_md_op),
      .src_a    (fwd_a),
      .src_b    (fwd_b),
      .busy     (md_busy),
      .result   (md_res)
   );

   assign res = EX_md_en ? md_res : alu_res;
`else
   logic unused_md;

   assign unused_md = ^{EX_md_en, EX_md_op};
   assign md_busy   = 1'b0;
   assign res       = alu_res;
`endif

   assign EX_md_busy = md_busy;

   // Next EX/MEM contents
   always_comb begin
      reg_d          = '0;
      reg_d.alu_data = res;
      reg_d.rs2_data = fwd_b;
      reg_d.rd_addr  = EX_rd_addr;
      reg_d.pc_four  = EX_pc + 32'd4;
      reg_d.rd_wren  = EX_rd_wren;
      reg_d.mem_en   = EX_mem_en;
      reg_d.wb_en    = EX_wb_en;
      reg_d.ld_en    = EX_ld_en;
      reg_d.pc_br    = br_take;
   end

   // EX/MEM register: flush clears, busy inserts a bubble
   always_ff @(posedge clk_i or negedge clr_n) begin
      if (!clr_n)
         reg_q <= '0;
      else if (EX_stall_en)
         reg_q <= md_busy ? '0 : reg_d;
   end

   assign ex_mem.MEM_alu_data = reg_q.alu_data;
   assign ex_mem.MEM_rs2_data = reg_q.rs2_data;
   assign ex_mem.MEM_rd_addr  = reg_q.rd_addr;
   assign ex_mem.MEM_pc_four  = reg_q.pc_four;
   assign ex_mem.MEM_rd_wren  = reg_q.rd_wren;
   assign ex_mem.MEM_mem_en   = reg_q.mem_en;
   assign ex_mem.MEM_wb_en    = reg_q.wb_en;
   assign ex_mem.MEM_ld_en    = reg_q.ld_en;
   assign ex_mem.MEM_pc_br    = reg_q.pc_br;

endmodule

// File: doc/ex_cycle.md
# ex_cycle
Execute stage of the 5-stage RV32I pipeline, sitting between the decode stage and `mem_cycle`. It selects forwarded operands, runs the ALU and branch comparator, and computes the branch/jump decision. It registers results plus pass-through control into the EX/MEM pipeline register that drives `mem_cycle`'s `MEM_*` inputs. With RV32M enabled, a multi-cycle multiply/divide unit stalls the pipeline through `EX_md_busy`.
## Interface
- Parameters: none; RV32, all widths fixed.
- clk_i  in  1  rising-edge clock
- rst_ni  in  1  asynchronous active-low reset
- EX_stall_en  in  1  1 = EX/MEM register loads, 0 = holds
- EX_rst_n  in  1  active-low flush; ANDed with rst_ni into the register's async clear
- EX_pc  in  32  PC of the instruction in EX
- EX_rs1_data  in  32  register-file rs1
- EX_rs2_data  in  32  register-file rs2
- EX_imm  in  32  sign-extended immediate
- EX_rd_addr  in  5  destination register
- EX_fwd_a_sel  in  2  rs1 source: 00 regfile, 01 MEM_alu_data, 10 WB_fwd_data, 11 regfile
- EX_fwd_b_sel  in  2  rs2 source, same encoding
- WB_fwd_data  in  32  final writeback data from WB stage
- EX_alu_op  in  4  ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, PASSB 10, JALR 11 ((A+B)&~1); others → 0
- EX_op_sel  in  2  bit0: A = PC (1) / rs1 (0); bit1: B = imm (1) / rs2 (0)
- EX_br_op  in  3  0 none, 1 BEQ, 2 BNE, 3 BLT, 4 BGE, 5 BLTU, 6 BGEU, 7 JUMP (always taken)
- EX_md_en  in  1  instruction is RV32M
- EX_md_op  in  3  RV32M funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
- EX_rd_wren  in  1  pass-through
- EX_mem_en  in  9  pass-through, mem_cycle bit layout
- EX_wb_en  in  2  pass-through
- EX_ld_en  in  1  pass-through
- MEM_alu_data  out  32  ALU/MD result, or branch/jump target; reset 0
- MEM_rs2_data  out  32  forwarded rs2, used as store data; reset 0
- MEM_rd_addr  out  5  reset 0
- MEM_pc_four  out  32  EX_pc + 4; reset 0
- MEM_rd_wren  out  1  reset 0
- MEM_mem_en  out  9  reset 0
- MEM_wb_en  out  2  reset 0
- MEM_ld_en  out  1  reset 0
- MEM_pc_br  out  1  branch taken or jump; reset 0
- EX_md_busy  out  1  combinational stall request to the hazard unit; 0 during reset
## Operation
- Operands: A = op_sel[0] ? EX_pc : fwd rs1; B = op_sel[1] ? EX_imm : fwd rs2. Shifts use B[4:0]. SLT is signed, SLTU unsigned. Arithmetic wraps mod 2^32.
- Branch: comparator always uses forwarded rs1/rs2. For branches, decode sets ADD with A = PC and B = imm, so MEM_alu_data carries the target. MEM_pc_br = compare result (1 for JUMP, 0 for none).
- MD unit: MUL* completes in one cycle (full 64-bit product; high/low half selected by op). DIV* is radix-2 restoring, 32 iterations, run on magnitudes with the sign fixed afterwards.
- MD FSM: IDLE → CALC on start (EX_md_en & div op & EX_stall_en in IDLE). CALC holds 32 cycles (5-bit counter), then → DONE. DONE → IDLE when EX_stall_en = 1, and stays in DONE otherwise.
- Divide special cases: divide by 0 gives quotient 0xFFFFFFFF and remainder = dividend. 0x80000000 / -1 gives quotient 0x80000000 and remainder 0.
## Timing
- ALU/MUL latency 1: inputs in cycle n appear on MEM_* after the rising edge that ends cycle n, provided EX_stall_en = 1.
- DIV: EX_md_busy = 1 in the start cycle and all 32 CALC cycles (33 cycles), and 0 in DONE, where the result is captured. MEM_* shows the result 34 edges after presentation.
- While EX_md_busy = 1, the register loads a bubble (all MEM_* = 0). Upstream must hold EX_* inputs stable.
- EX_rst_n = 0 clears the register and aborts the FSM to IDLE immediately, including mid-CALC. Flush has priority over EX_stall_en. rst_ni = 0 acts the same, asynchronously.
## Configuration
- `RV32M_EN`: when defined, the MD unit is compiled in. When undefined, EX_md_en/EX_md_op are ignored, the ALU result is used, EX_md_busy is tied to 0, and no FSM or multiplier exists. Ports are identical in both builds.
## Structure
- `ex_pkg` holds enums alu_op_e, br_op_e, md_op_e and fwd_sel_e, plus localparam DIV_ITER = 32. Sub-module `md_unit` contains the multiplier, the divider FSM, busy and result.
## Test plan
- Forwarding: rs1 = 5 with fwd_a_sel = 01 and MEM_alu_data = 7; ADD, B = imm 3 → MEM_alu_data = 10 after one edge.
- BLT: rs1 = 0xFFFFFFFF, rs2 = 1, PC = 0x100, imm = 0x20 → MEM_pc_br = 1, MEM_alu_data = 0x120. Same operands with BLTU → MEM_pc_br = 0.
- DIV -7 / 2 (RV32M_EN) → busy for 33 cycles, bubbles on MEM_*, then MEM_alu_data = 0xFFFFFFFD. REM → 0xFFFFFFFF. DIVU by 0 → 0xFFFFFFFF.
- Flush at CALC cycle 10 → FSM returns to IDLE, busy = 0 next cycle, MEM_* = 0. Also hold EX_stall_en = 0 in DONE for 3 cycles → DONE is held and the result is captured on release.
